// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the LC-3b datapath and its pipeline sequencer.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    // Datapath status into the sequencer
    logic                 imem_resp;
    logic                 de_use_sr1;
    logic                 de_use_sr2;
    logic [2:0]           de_sr1;
    logic [2:0]           de_sr2;
    logic                 de_ldreg;
    logic [2:0]           de_drid;
    logic                 de_setcc;
    logic                 de_usecc;
    logic                 mem_access;
    logic                 dmem_resp;
    logic                 mem_br_taken;

    // Sequencer controls back to the datapath
    logic                 load_pc;
    logic                 pc_sel_target;
    logic                 load_de;
    logic                 load_agex;
    logic                 load_mem;
    logic                 load_sr;
    logic                 v_de;
    logic                 v_agex;
    logic                 v_mem;
    logic                 v_sr;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    modport master (
        output imem_resp, de_use_sr1, de_use_sr2, de_sr1, de_sr2, de_ldreg, de_drid,
               de_setcc, de_usecc, mem_access, dmem_resp, mem_br_taken,
        input  load_pc, pc_sel_target, load_de, load_agex, load_mem, load_sr,
               v_de, v_agex, v_mem, v_sr, stall_cnt, flush_cnt
    );

    modport slave (
        input  imem_resp, de_use_sr1, de_use_sr2, de_sr1, de_sr2, de_ldreg, de_drid,
               de_setcc, de_usecc, mem_access, dmem_resp, mem_br_taken,
        output load_pc, pc_sel_target, load_de, load_agex, load_mem, load_sr,
               v_de, v_agex, v_mem, v_sr, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage LC-3b core (FE -> DE -> AGEX -> MEM -> SR).
// Produces latch-bank load enables, stage valid bits, hazard stalls, branch squash
// and saturating stall/flush counters.
module pipe_ctrl #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave ctrl_if
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMwait    = 2'd1,
        StRedirect = 2'd2
    } state_e;

    state_e               r_state;
    logic                 r_v_de, r_v_agex, r_v_mem, r_v_sr;
    // In-flight writer scoreboard, one entry per stage past DE
    logic                 r_agex_ldreg, r_mem_ldreg, r_sr_ldreg;
    logic [2:0]           r_agex_drid, r_mem_drid, r_sr_drid;
    logic                 r_agex_setcc, r_mem_setcc, r_sr_setcc;
    logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;

    logic w_sr1_busy, w_sr2_busy, w_cc_busy;
    logic w_mem_stall, w_dep_stall, w_flush, w_fetch, w_agex_in, w_stall_evt;

    assign w_sr1_busy = (r_v_agex & r_agex_ldreg & (r_agex_drid == ctrl_if.de_sr1))
                      | (r_v_mem  & r_mem_ldreg  & (r_mem_drid  == ctrl_if.de_sr1))
                      | (r_v_sr   & r_sr_ldreg   & (r_sr_drid   == ctrl_if.de_sr1));
    assign w_sr2_busy = (r_v_agex & r_agex_ldreg & (r_agex_drid == ctrl_if.de_sr2))
                      | (r_v_mem  & r_mem_ldreg  & (r_mem_drid  == ctrl_if.de_sr2))
                      | (r_v_sr   & r_sr_ldreg   & (r_sr_drid   == ctrl_if.de_sr2));
    assign w_cc_busy  = (r_v_agex & r_agex_setcc) | (r_v_mem & r_mem_setcc)
                      | (r_v_sr & r_sr_setcc);

    assign w_mem_stall = r_v_mem & ctrl_if.mem_access & ~ctrl_if.dmem_resp;
    assign w_dep_stall = r_v_de & ((ctrl_if.de_use_sr1 & w_sr1_busy)
                                 | (ctrl_if.de_use_sr2 & w_sr2_busy)
                                 | (ctrl_if.de_usecc & w_cc_busy));
    assign w_flush     = r_v_mem & ctrl_if.mem_br_taken & ~w_mem_stall;
    // The I-cache response in the redirect cycle belongs to the wrong path
    assign w_fetch     = ctrl_if.imem_resp & (r_state != StRedirect);
    assign w_agex_in   = r_v_de & ~w_dep_stall & ~w_flush;
    // A dep stall coinciding with a flush is moot: the DE instruction dies
    assign w_stall_evt = w_mem_stall | (w_dep_stall & ~w_flush);

    assign ctrl_if.load_sr       = 1'b1;
    assign ctrl_if.load_mem      = ~w_mem_stall;
    assign ctrl_if.load_agex     = ~w_mem_stall;
    assign ctrl_if.load_de       = ~w_mem_stall & (w_flush | ~w_dep_stall);
    assign ctrl_if.load_pc       = ~w_mem_stall & (w_flush | (w_fetch & ~w_dep_stall));
    assign ctrl_if.pc_sel_target = w_flush;
    assign ctrl_if.v_de          = r_v_de;
    assign ctrl_if.v_agex        = r_v_agex;
    assign ctrl_if.v_mem         = r_v_mem;
    assign ctrl_if.v_sr          = r_v_sr;
    assign ctrl_if.stall_cnt     = r_stall_cnt;
    assign ctrl_if.flush_cnt     = r_flush_cnt;

    // Advance stage valid bits and scoreboard, or freeze DE..MEM on a memory stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v_de       <= 1'b0;
            r_v_agex     <= 1'b0;
            r_v_mem      <= 1'b0;
            r_v_sr       <= 1'b0;
            r_agex_ldreg <= 1'b0;
            r_agex_drid  <= 3'd0;
            r_agex_setcc <= 1'b0;
            r_mem_ldreg  <= 1'b0;
            r_mem_drid   <= 3'd0;
            r_mem_setcc  <= 1'b0;
            r_sr_ldreg   <= 1'b0;
            r_sr_drid    <= 3'd0;
            r_sr_setcc   <= 1'b0;
        end else if (w_mem_stall) begin
            r_v_sr <= 1'b0;
        end else begin
            r_v_sr       <= r_v_mem;
            r_v_mem      <= r_v_agex & ~w_flush;
            r_v_agex     <= w_agex_in;
            r_v_de       <= w_flush ? 1'b0 : (w_dep_stall ? r_v_de : w_fetch);
            r_sr_ldreg   <= r_mem_ldreg;
            r_sr_drid    <= r_mem_drid;
            r_sr_setcc   <= r_mem_setcc;
            r_mem_ldreg  <= r_agex_ldreg;
            r_mem_drid   <= r_agex_drid;
            r_mem_setcc  <= r_agex_setcc;
            r_agex_ldreg <= ctrl_if.de_ldreg & w_agex_in;
            r_agex_drid  <= ctrl_if.de_drid;
            r_agex_setcc <= ctrl_if.de_setcc & w_agex_in;
        end
    end

    // Sequencer state: flush wins, then memory wait, otherwise run
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StRun;
        end else begin
            unique case (r_state)
                StRun, StMwait, StRedirect: begin
                    if (w_flush) begin
                        r_state <= StRedirect;
                    end else if (w_mem_stall) begin
                        r_state <= StMwait;
                    end else begin
                        r_state <= StRun;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage LC-3b core: FE -> DE -> AGEX -> MEM -> SR.
- Generates the load enables for the DE/AGEX/MEM/SR stage latches (e.g. load_agex_* of the AGEX latch bank) and the PC load, and tracks a valid bit per stage.
- Detects memory stalls, RAW register hazards and CC hazards against in-flight instructions, and squashes wrong-path instructions on a taken branch resolved in MEM.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- imem_resp  in  1  I-cache returns a valid instruction this cycle
- de_use_sr1  in  1  instruction in DE reads SR1
- de_use_sr2  in  1  instruction in DE reads SR2
- de_sr1  in  3  SR1 id of DE instruction
- de_sr2  in  3  SR2 id of DE instruction
- de_ldreg  in  1  DE instruction writes a register
- de_drid  in  3  DE destination register id
- de_setcc  in  1  DE instruction writes CC
- de_usecc  in  1  DE instruction is a BR (reads CC)
- mem_access  in  1  MEM instruction needs the D-cache
- dmem_resp  in  1  D-cache completes this cycle
- mem_br_taken  in  1  MEM instruction is a resolved taken branch/jump
- load_pc  out  1  load PC
- pc_sel_target  out  1  PC takes branch target (else PC+2)
- load_de  out  1  load DE latch bank
- load_agex  out  1  load AGEX latch bank
- load_mem  out  1  load MEM latch bank
- load_sr  out  1  load SR latch bank
- v_de, v_agex, v_mem, v_sr  out  1 each  stage-valid bits; an invalid stage is a bubble
- stall_cnt  out  CNT_WIDTH  cycles with mem_stall or dep_stall
- flush_cnt  out  CNT_WIDTH  number of flushes

Behaviour:
- Reset: all v_* = 0; internal ldreg/drid/setcc scoreboard = 0; both counters = 0; state = RUN.
- Scoreboard: per stage AGEX/MEM/SR holds {ldreg, drid, setcc}. It shifts with the valid bits and is qualified by them.
- mem_stall = v_mem & mem_access & ~dmem_resp.
- dep_stall = v_de & any of the following:
  - de_use_sr1 and sr1 matches a valid in-flight ldreg drid (AGEX, MEM or SR);
  - the same check for SR2;
  - de_usecc and any valid in-flight setcc.
- flush = v_mem & mem_br_taken & ~mem_stall.
- Priority: mem_stall > flush > dep_stall.
- Combinational outputs:
  - load_sr = 1.
  - load_mem = load_agex = ~mem_stall.
  - load_de = ~mem_stall & (flush | ~dep_stall).
  - load_pc = ~mem_stall & (flush | (imem_resp & ~dep_stall)).
  - pc_sel_target = flush.
- Next state when mem_stall:
  - v_sr <= 0 (bubble into SR).
  - MEM, AGEX and DE hold their valid bits and scoreboard entries.
- Next state otherwise:
  - v_sr <= v_mem.
  - v_mem <= v_agex & ~flush.
  - v_agex <= v_de & ~dep_stall & ~flush.
  - v_de <= flush ? 0 : (dep_stall ? v_de : imem_resp).
  - Scoreboard fields move with their stage. An AGEX bubble carries ldreg = setcc = 0.
- FSM, state = RUN / MWAIT / REDIRECT:
  - RUN -> MWAIT on mem_stall.
  - MWAIT -> RUN when dmem_resp arrives with no taken branch.
  - RUN or MWAIT -> REDIRECT when flush occurs.
  - REDIRECT lasts exactly 1 cycle, then -> RUN, or -> MWAIT if mem_stall.
  - During REDIRECT, imem_resp is ignored and v_de <= 0; the first post-flush fetch is accepted on the following cycle.
- Counters: stall_cnt += 1 on any cycle with mem_stall | dep_stall; flush_cnt += 1 per flush. Both saturate at all-ones and never wrap.
- Reset mid-stall or mid-redirect: all valids clear next edge, FSM -> RUN, and no load is suppressed after the reset cycle.
- Simultaneous mem_stall and mem_br_taken: no flush until dmem_resp arrives; the flush then occurs in the completing cycle.
- A dep_stall in the same cycle as a flush is discarded, since the DE instruction is squashed.

Test Plan:
- Reset mid-stream -> next cycle all v_* = 0, counters = 0, load_* = 1 with imem_resp = 1, state RUN.
- ADD R1 followed immediately by ADD R2,R1,R3 -> dep_stall for 3 cycles (producer in AGEX, MEM, SR); v_agex = 0 bubbles; stall_cnt = 3; consumer issues on the 4th cycle.
- LDR in MEM with dmem_resp low for 4 cycles -> load_mem = load_agex = load_de = 0 for 4 cycles, v_sr = 0 bubbles, MWAIT held; stall_cnt = 4; resumes on the cycle dmem_resp = 1.
- Taken BR reaches MEM with v_de = v_agex = 1 -> flush: pc_sel_target = 1, load_pc = 1, v_agex/v_de cleared next cycle; REDIRECT for 1 cycle; flush_cnt = 1.
- Taken BR in MEM with dmem_resp delayed 2 cycles -> no flush for 2 cycles, then flush on the completing cycle; stall_cnt = 2, flush_cnt = 1.
- Force stall_cnt to all-ones minus 1 with CNT_WIDTH = 4, then 3 stall cycles -> counter stops at 15.
